chip_checker_input_cond: RTL and testbench



---
 rtl/chip_checker_input_cond.sv | 161 ++++++++++++++++
 tb/tb_chip_checker_input_cond.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip_checker_input_cond.sv
// ---------------------------------------------------------------------------
// chip_checker_input_cond
//   Input conditioner in front of the chip-checker control FSM and test
//   engines. Synchronizes and debounces the raw Run button and the ten slide
//   switches, then derives a one-cycle Run press strobe, a stable switch bus
//   with a change strobe, and a slow step Tick used as a clock enable.
//
// Ports
//   Clk         system clock, rising edge
//   Reset       synchronous active-high reset
//   Run_n       raw Run push-button, 0 = pressed (async, bouncy)
//   SW[9:0]     raw slide switches (async, bouncy)
//   Run_level   debounced Run, 1 = pressed
//   Run_pulse   one-cycle strobe on an accepted press
//   SW_stable   debounced switch value
//   SW_changed  one-cycle strobe whenever SW_stable updates
//   Tick        one-cycle strobe every TICK_DIV cycles
//   Tick_phase  toggles on every Tick (display heartbeat)
// ---------------------------------------------------------------------------

// One conditioning channel: synchronizer chain followed by a debouncer.
// accept_o is high in the cycle whose rising edge loads the new stable value.
module chip_checker_input_cond_ch #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit RST_VAL         = 1'b0
) (
    input  logic Clk,
    input  logic Reset,
    input  logic raw_i,
    output logic stable_o,
    output logic accept_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   stable_q, stable_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   accept;

    assign synced = sync_q[SYNC_STAGES-1];

    // Counter only advances while the synced value disagrees with the stable
    // value; any single agreeing sample throws away the progress so far.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        if (synced == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
            stable_d = synced;
            cnt_d    = '0;
            accept   = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_q   <= {SYNC_STAGES{RST_VAL}};
            stable_q <= RST_VAL;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign accept_o = accept;
endmodule

module chip_checker_input_cond #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_DIV        = 50000000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run_n,
    input  logic [9:0] SW,
    output logic       Run_level,
    output logic       Run_pulse,
    output logic [9:0] SW_stable,
    output logic       SW_changed,
    output logic       Tick,
    output logic       Tick_phase
);
    localparam int NCH = 11;                 // bit 10 = Run_n, bits 9:0 = SW
    localparam int TW  = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [NCH-1:0] raw;
    logic [NCH-1:0] ch_stable;
    logic [NCH-1:0] ch_accept;

    logic          run_pulse_q, run_pulse_d;
    logic          sw_changed_q, sw_changed_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          phase_q, phase_d;
    logic          tick;

    assign raw = {Run_n, SW};

    // Run channel resets to 1 (button released), switches reset to 0.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        chip_checker_input_cond_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RST_VAL        (c == NCH - 1)
        ) u_ch (
            .Clk     (Clk),
            .Reset   (Reset),
            .raw_i   (raw[c]),
            .stable_o(ch_stable[c]),
            .accept_o(ch_accept[c])
        );
    end

    // Strobes are registered from the same edge that loads the stable value,
    // so they line up with the first cycle showing the new value. A press is
    // an accept while the button is currently released; releases are ignored.
    assign run_pulse_d  = ch_accept[NCH-1] & ch_stable[NCH-1];
    assign sw_changed_d = |ch_accept[NCH-2:0];

    // A press restarts the tick period; a Tick coinciding with the press
    // still counts and still flips the phase.
    assign tick = (tick_cnt_q == TICK_LAST);

    always_comb begin
        tick_cnt_d = tick_cnt_q + 1'b1;
        if (run_pulse_q || tick) tick_cnt_d = '0;
        phase_d = phase_q ^ tick;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            run_pulse_q  <= 1'b0;
            sw_changed_q <= 1'b0;
            tick_cnt_q   <= '0;
            phase_q      <= 1'b0;
        end else begin
            run_pulse_q  <= run_pulse_d;
            sw_changed_q <= sw_changed_d;
            tick_cnt_q   <= tick_cnt_d;
            phase_q      <= phase_d;
        end
    end

    assign Run_level  = ~ch_stable[NCH-1];
    assign Run_pulse  = run_pulse_q;
    assign SW_stable  = ch_stable[NCH-2:0];
    assign SW_changed = sw_changed_q;
    assign Tick       = tick;
    assign Tick_phase = phase_q;
endmodule

// File: tb/tb_chip_checker_input_cond.sv
// ---------------------------------------------------------------------------
// tb_chip_checker_input_cond
//   Self-checking bench for chip_checker_input_cond with SYNC_STAGES=2,
//   DEBOUNCE_CYCLES=4, TICK_DIV=8. "Cycle N" means the output values present
//   at rising edge N, where edge 0 is the first edge with Reset low. The
//   reference model accepts a channel change when the last D synchronized
//   samples since reset all disagree with the stable value, and derives Tick
//   from the distance to the last counter restart.
// ---------------------------------------------------------------------------
module tb_chip_checker_input_cond;
    localparam int S  = 2;
    localparam int D  = 4;
    localparam int TD = 8;
    localparam logic [10:0] RST_CH = 11'h400;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Run_n = 1'b1;
    logic [9:0] SW = '0;
    logic       Run_level, Run_pulse, SW_changed, Tick, Tick_phase;
    logic [9:0] SW_stable;
    logic [14:0] obs;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [10:0] hist[$];
    logic [10:0] m_stable = RST_CH;
    logic        m_pulse = 1'b0;
    logic        m_changed = 1'b0;
    logic        m_phase = 1'b0;
    int          base = 0;
    int          cyc = 0;

    chip_checker_input_cond #(
        .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .TICK_DIV(TD)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Run_n(Run_n), .SW(SW),
        .Run_level(Run_level), .Run_pulse(Run_pulse), .SW_stable(SW_stable),
        .SW_changed(SW_changed), .Tick(Tick), .Tick_phase(Tick_phase)
    );

    always #5 Clk = ~Clk;

    assign obs = {Run_level, Run_pulse, SW_stable, SW_changed, Tick, Tick_phase};

    function automatic logic [14:0] exp_vec();
        logic t;
        t = (((cyc - base) % TD) == TD - 1);
        return {~m_stable[10], m_pulse, m_stable[9:0], m_changed, t, m_phase};
    endfunction

    // Drive inputs for the next edge, take the edge, and advance the model.
    task automatic step(input logic rn, input logic [9:0] sw, input logic rst);
        logic [10:0] acc;
        logic [10:0] sv;
        logic        ok;
        Run_n = rn;
        SW    = sw;
        Reset = rst;
        @(posedge Clk);
        #1;
        if (rst) begin
            hist.delete();
            m_stable  = RST_CH;
            m_pulse   = 1'b0;
            m_changed = 1'b0;
            m_phase   = 1'b0;
            base      = 0;
            cyc       = 0;
        end else begin
            hist.push_back({rn, sw});
            acc = '0;
            if (cyc >= D - 1) begin
                for (int b = 0; b < 11; b++) begin
                    ok = 1'b1;
                    for (int j = cyc - D + 1; j <= cyc; j++) begin
                        sv = (j >= S) ? hist[j - S] : RST_CH;
                        if (sv[b] == m_stable[b]) ok = 1'b0;
                    end
                    acc[b] = ok;
                end
            end
            if (((cyc - base) % TD) == TD - 1) m_phase = ~m_phase;
            if (m_pulse) base = cyc + 1;
            m_pulse   = acc[10] & m_stable[10];
            m_changed = |acc[9:0];
            m_stable  = m_stable ^ acc;
            cyc++;
        end
    endtask

    task automatic test_reset();
        step(1'b0, 10'h3FF, 1'b1);
        step(1'b1, 10'h000, 1'b1);
        checks++;
        if (obs !== 15'h0000) begin
            errors++; $display("FAIL reset_state: got %h want %h", obs, 15'h0000);
        end
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("FAIL reset_model: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_idle_tick();
        step(1'b1, 10'h0, 1'b1);
        for (int c = 0; c < 26; c++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL idle_model c%0d: got %h want %h", cyc, obs, exp_vec());
            end
            checks++;
            if (Tick !== 1'((cyc == 7) || (cyc == 15) || (cyc == 23))) begin
                errors++; $display("FAIL idle_tick c%0d: got %b", cyc, Tick);
            end
            checks++;
            if (Tick_phase !== 1'((cyc / 8) % 2)) begin
                errors++; $display("FAIL idle_phase c%0d: got %b want %0d", cyc, Tick_phase, (cyc / 8) % 2);
            end
            checks++;
            if ({Run_level, Run_pulse, SW_changed} !== 3'b000) begin
                errors++; $display("FAIL idle_quiet c%0d: got %b want 000", cyc, {Run_level, Run_pulse, SW_changed});
            end
            step(1'b1, 10'h0, 1'b0);
        end
    endtask

    task automatic test_run_press();
        step(1'b1, 10'h0, 1'b1);
        for (int c = 0; c < 34; c++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL press_model c%0d: got %h want %h", cyc, obs, exp_vec());
            end
            checks++;
            if (Run_pulse !== 1'(cyc == 16)) begin
                errors++; $display("FAIL press_pulse c%0d: got %b", cyc, Run_pulse);
            end
            checks++;
            if (Run_level !== 1'((cyc >= 16) && (cyc < 28))) begin
                errors++; $display("FAIL press_level c%0d: got %b", cyc, Run_level);
            end
            checks++;
            if (Tick !== 1'((cyc == 7) || (cyc == 15) || (cyc == 24) || (cyc == 32))) begin
                errors++; $display("FAIL press_tick c%0d: got %b", cyc, Tick);
            end
            step(((cyc >= 10) && (cyc < 22)) ? 1'b0 : 1'b1, 10'h0, 1'b0);
        end
    endtask

    task automatic test_bounce();
        step(1'b1, 10'h0, 1'b1);
        for (int c = 0; c < 16; c++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL bounce_model c%0d: got %h want %h", cyc, obs, exp_vec());
            end
            checks++;
            if ({Run_level, Run_pulse} !== 2'b00) begin
                errors++; $display("FAIL bounce_run c%0d: got %b want 00", cyc, {Run_level, Run_pulse});
            end
            step(((cyc >= 2 && cyc <= 4) || (cyc >= 6 && cyc <= 8)) ? 1'b0 : 1'b1, 10'h0, 1'b0);
        end
    endtask

    task automatic test_sw();
        logic [9:0] want;
        step(1'b1, 10'h0, 1'b1);
        for (int c = 0; c < 26; c++) begin
            want = (cyc >= 19) ? 10'h2A4 : (cyc >= 11) ? 10'h2A5 : 10'h000;
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL sw_model c%0d: got %h want %h", cyc, obs, exp_vec());
            end
            checks++;
            if (SW_stable !== want) begin
                errors++; $display("FAIL sw_stable c%0d: got %h want %h", cyc, SW_stable, want);
            end
            checks++;
            if (SW_changed !== 1'((cyc == 11) || (cyc == 19))) begin
                errors++; $display("FAIL sw_changed c%0d: got %b", cyc, SW_changed);
            end
            step(1'b1, (cyc < 5) ? 10'h000 : (cyc < 13) ? 10'h2A5 : 10'h2A4, 1'b0);
        end
    endtask

    task automatic test_collision();
        step(1'b1, 10'h0, 1'b1);
        for (int c = 0; c < 36; c++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL coll_model c%0d: got %h want %h", cyc, obs, exp_vec());
            end
            checks++;
            if (Run_pulse !== 1'(cyc == 15)) begin
                errors++; $display("FAIL coll_pulse c%0d: got %b", cyc, Run_pulse);
            end
            checks++;
            if (Tick !== 1'((cyc % 8) == 7)) begin
                errors++; $display("FAIL coll_tick c%0d: got %b", cyc, Tick);
            end
            checks++;
            if (Tick_phase !== 1'((cyc / 8) % 2)) begin
                errors++; $display("FAIL coll_phase c%0d: got %b want %0d", cyc, Tick_phase, (cyc / 8) % 2);
            end
            step(((cyc >= 9) && (cyc < 20)) ? 1'b0 : 1'b1, 10'h0, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 10'h0, 1'b1);
        // Run and SW change at cycle 2; at cycle 6 the Run counter holds 2.
        for (int c = 0; c < 7; c++) begin
            checks++;
            if ({Run_pulse, SW_changed} !== 2'b00 || obs !== exp_vec()) begin
                errors++; $display("FAIL rmid_pre c%0d: got %h want %h", cyc, obs, exp_vec());
            end
            if (c < 6) step((cyc >= 2) ? 1'b0 : 1'b1, (cyc >= 2) ? 10'h155 : 10'h000, 1'b0);
        end
        step(1'b0, 10'h155, 1'b1);
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL rmid_model c%0d: got %h want %h", cyc, obs, exp_vec());
            end
            checks++;
            if ({Run_pulse, SW_changed} !== {2{1'(cyc == 6)}}) begin
                errors++; $display("FAIL rmid_strobes c%0d: got %b", cyc, {Run_pulse, SW_changed});
            end
            checks++;
            if (SW_stable !== ((cyc >= 6) ? 10'h155 : 10'h000) || Run_level !== 1'(cyc >= 6)) begin
                errors++; $display("FAIL rmid_level c%0d: got sw=%h run=%b", cyc, SW_stable, Run_level);
            end
            step(1'b0, 10'h155, 1'b0);
        end
    endtask

    task automatic test_random();
        logic       rn;
        logic [9:0] sw;
        int         hold;
        rn = 1'b1; sw = '0; hold = 0;
        step(1'b1, 10'h0, 1'b1);
        for (int c = 0; c < 600; c++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL random_model i%0d c%0d: got %h want %h", c, cyc, obs, exp_vec());
            end
            if (hold == 0) begin
                hold = $urandom_range(1, 10);
                rn   = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 2) == 0) sw = 10'($urandom);
                else sw = sw ^ 10'(1 << $urandom_range(0, 9));
            end
            hold--;
            step(rn, sw, 1'($urandom_range(0, 149) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_idle_tick();
        test_run_press();
        test_bounce();
        test_sw();
        test_collision();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
